// File: rtl/atp_pkg.sv
// atp_pkg: shared types and defaults for the ATP shared-resource arbiters
package atp_pkg;
  typedef enum logic [1:0] {IDLE, START, PRINT, RELEASE} arb_state_t;
  typedef enum logic {ST_OK, ST_ERR} job_status_t;
  localparam int N_KIOSK_DEF = 4;
  localparam int TIMEOUT_DEF = 1024;
endpackage

// File: rtl/atp_printer_arbiter_if.sv
// atp_printer_arbiter_if: kiosk request/grant and printer handshake bundle
interface atp_printer_arbiter_if import atp_pkg::*; #(
  parameter int N_KIOSK = N_KIOSK_DEF
) ();
  localparam int IW = $clog2(N_KIOSK);
  logic [N_KIOSK-1:0] req;
  logic [N_KIOSK-1:0] grant;
  logic [N_KIOSK-1:0] job_done;
  logic [N_KIOSK-1:0] job_err;
  logic               prn_start;
  logic [IW-1:0]      prn_kiosk_id;
  logic               prn_done;
  logic               prn_abort;
  logic               busy;
  modport master (
    output req, prn_done,
    input  grant, job_done, job_err, prn_start, prn_kiosk_id, prn_abort, busy
  );
  modport slave (
    input  req, prn_done,
    output grant, job_done, job_err, prn_start, prn_kiosk_id, prn_abort, busy
  );
endinterface

// File: rtl/atp_rr_pick.sv
// atp_rr_pick: combinational round-robin picker, first set bit after last with wrap
module atp_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic                 valid,
  output logic [$clog2(N)-1:0] idx
);
  logic [$clog2(N)-1:0] j;
  // scan downward so the nearest candidate after last is the final assignment
  always_comb begin
    valid = 1'b0;
    idx = '0;
    j = '0;
    for (int i = N; i >= 1; i--) begin
      j = $clog2(N)'((int'(last) + i) % N);
      if (req[j]) begin
        valid = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/atp_printer_arbiter.sv
// atp_printer_arbiter: round-robin receipt printer sharing; timeout abort under ATP_PRN_TIMEOUT_EN
module atp_printer_arbiter import atp_pkg::*; #(
  parameter int N_KIOSK = N_KIOSK_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input logic clk,
  input logic reset,
  atp_printer_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_KIOSK);
  arb_state_t state_q, state_d;
  job_status_t st;
  logic [IW-1:0] last_q, last_d, idx_q, idx_d, pick_idx;
  logic [N_KIOSK-1:0] grant_q, grant_d, done_q, done_d;
  logic start_q, start_d, busy_q, busy_d, pick_valid, tmo, fin;
  atp_rr_pick #(.N(N_KIOSK)) u_pick (
    .req(bus.req),
    .last(last_q),
    .valid(pick_valid),
    .idx(pick_idx)
  );
`ifdef ATP_PRN_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N_KIOSK-1:0] err_q, err_d;
  logic abort_q, abort_d;
  assign tmo = state_q == PRINT && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  // PRINT-cycle counter, cleared while in START so it starts at zero in PRINT
  always_comb begin
    cnt_d = state_q == START ? '0 : state_q == PRINT ? cnt_q + 1'b1 : cnt_q;
    err_d = fin && st == ST_ERR ? N_KIOSK'(1) << idx_q : '0;
    abort_d = fin && st == ST_ERR;
  end
  // timeout counter and error pulses
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt_q <= '0;
      err_q <= '0;
      abort_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      abort_q <= abort_d;
    end
  assign bus.job_err = err_q;
  assign bus.prn_abort = abort_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
  assign tmo = 1'b0;
  assign bus.job_err = '0;
  assign bus.prn_abort = 1'b0;
`endif
  // next state and next registered outputs; prn_done wins over a same-cycle timeout
  always_comb begin
    st = bus.prn_done ? ST_OK : ST_ERR;
    fin = state_q == PRINT && (bus.prn_done || tmo);
    state_d = state_q == IDLE ? (pick_valid ? START : IDLE) :
              state_q == START ? PRINT :
              state_q == PRINT ? (fin ? RELEASE : PRINT) : IDLE;
    idx_d = state_q == IDLE && pick_valid ? pick_idx : idx_q;
    last_d = state_q == RELEASE ? idx_q : last_q;
    grant_d = state_d == START || state_d == PRINT ? N_KIOSK'(1) << idx_d : '0;
    start_d = state_d == START;
    busy_d = state_d != IDLE;
    done_d = fin && st == ST_OK ? N_KIOSK'(1) << idx_q : '0;
  end
  // FSM state, round-robin pointer and registered outputs
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      last_q <= IW'(N_KIOSK - 1);
      idx_q <= '0;
      grant_q <= '0;
      start_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      idx_q <= idx_d;
      grant_q <= grant_d;
      start_q <= start_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  assign bus.grant = grant_q;
  assign bus.prn_start = start_q;
  assign bus.prn_kiosk_id = idx_q;
  assign bus.job_done = done_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_atp_printer_arbiter.sv
// tb_atp_printer_arbiter: table-driven check of the printer arbiter
module tb_atp_printer_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int nvec = 0;
  int nerr = 0;
  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [16:0] exp;
  } vec_t;
  vec_t tv[$];
  atp_printer_arbiter_if #(.N_KIOSK(4)) bus ();
  atp_printer_arbiter #(.N_KIOSK(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  // packed view: grant, start, id, done, err, abort, busy
  function automatic logic [16:0] o(logic [3:0] g, logic s, logic [1:0] id, logic [3:0] d, logic b);
    return {g, s, id, d, 4'b0, 1'b0, b};
  endfunction
  function automatic logic [16:0] outs();
    return {bus.grant, bus.prn_start, bus.prn_kiosk_id, bus.job_done, bus.job_err, bus.prn_abort, bus.busy};
  endfunction
  task automatic add(logic r, logic [3:0] q, logic d, logic [16:0] e);
    tv.push_back('{r, q, d, e});
  endtask
  task automatic chk(string name, logic [16:0] act, logic [16:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic ok;
    bus.req = '0;
    bus.prn_done = 1'b0;
    // single request, done 5 cycles after start
    add(0, 4'h1, 0, o(4'h1, 1, 0, 4'h0, 1));
    for (int i = 0; i < 5; i++) add(0, 4'h1, 0, o(4'h1, 0, 0, 4'h0, 1));
    add(0, 4'h1, 1, o(4'h0, 0, 0, 4'h1, 1));
    add(0, 4'h0, 0, o(4'h0, 0, 0, 4'h0, 0));
    // all four requesting from reset: order 0,1,2,3,0
    add(1, 4'h0, 0, o(4'h0, 0, 0, 4'h0, 0));
    for (int j = 0; j < 5; j++) begin
      logic [1:0] k;
      k = 2'(j % 4);
      add(0, 4'hF, 0, o(4'h1 << k, 1, k, 4'h0, 1));
      for (int i = 0; i < 3; i++) add(0, 4'hF, 0, o(4'h1 << k, 0, k, 4'h0, 1));
      add(0, 4'hF, 1, o(4'h0, 0, k, 4'h1 << k, 1));
      add(0, 4'hF, 0, o(4'h0, 0, k, 4'h0, 0));
    end
    // req dropped mid-job; prn_done in IDLE and START ignored
    add(0, 4'h4, 1, o(4'h4, 1, 2, 4'h0, 1));
    add(0, 4'h0, 1, o(4'h4, 0, 2, 4'h0, 1));
    add(0, 4'h0, 0, o(4'h4, 0, 2, 4'h0, 1));
    add(0, 4'h0, 1, o(4'h0, 0, 2, 4'h4, 1));
    add(0, 4'h0, 0, o(4'h0, 0, 2, 4'h0, 0));
    // reset during PRINT reinitialises the pointer
    add(0, 4'h8, 0, o(4'h8, 1, 3, 4'h0, 1));
    add(0, 4'h8, 0, o(4'h8, 0, 3, 4'h0, 1));
    add(1, 4'h8, 0, o(4'h0, 0, 0, 4'h0, 0));
    add(0, 4'hA, 0, o(4'h2, 1, 1, 4'h0, 1));
    add(0, 4'h0, 0, o(4'h2, 0, 1, 4'h0, 1));
    add(0, 4'h0, 1, o(4'h0, 0, 1, 4'h2, 1));
    add(0, 4'h0, 0, o(4'h0, 0, 1, 4'h0, 0));
    repeat (2) @(posedge clk);
    #1;
    chk("reset", outs(), 17'h0);
    reset = 1'b0;
    foreach (tv[i]) begin
      reset = tv[i].rst;
      bus.req = tv[i].req;
      bus.prn_done = tv[i].done;
      step();
      chk($sformatf("vec%0d", i), outs(), tv[i].exp);
    end
    reset = 1'b0;
    bus.prn_done = 1'b0;
`ifdef ATP_PRN_TIMEOUT_EN
    // no prn_done: abort after 8 PRINT cycles
    bus.req = 4'h1;
    step();
    chk("tmo_start", outs(), o(4'h1, 1, 0, 4'h0, 1));
    bus.req = 4'h0;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      ok &= outs() == o(4'h1, 0, 0, 4'h0, 1);
    end
    chk("tmo_hold", {16'h0, ok}, 17'h1);
    step();
    chk("tmo_abort", outs(), {4'h0, 1'b0, 2'd0, 4'h0, 4'h1, 1'b1, 1'b1});
    step();
    chk("tmo_idle", outs(), o(4'h0, 0, 0, 4'h0, 0));
    // prn_done on the timeout cycle wins
    bus.req = 4'h1;
    step();
    chk("race_start", outs(), o(4'h1, 1, 0, 4'h0, 1));
    bus.req = 4'h0;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      ok &= outs() == o(4'h1, 0, 0, 4'h0, 1);
    end
    chk("race_hold", {16'h0, ok}, 17'h1);
    bus.prn_done = 1'b1;
    step();
    chk("race_done", outs(), o(4'h0, 0, 0, 4'h1, 1));
    bus.prn_done = 1'b0;
    step();
    chk("race_idle", outs(), o(4'h0, 0, 0, 4'h0, 0));
`else
    // no prn_done for 5000 cycles: grant held, never aborted
    bus.req = 4'h1;
    step();
    chk("hold_start", outs(), o(4'h1, 1, 0, 4'h0, 1));
    bus.req = 4'h0;
    ok = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      step();
      ok &= outs() == o(4'h1, 0, 0, 4'h0, 1);
    end
    chk("hold_5000", {16'h0, ok}, 17'h1);
    bus.prn_done = 1'b1;
    step();
    chk("hold_done", outs(), o(4'h0, 0, 0, 4'h1, 1));
    bus.prn_done = 1'b0;
    step();
    chk("hold_idle", outs(), o(4'h0, 0, 0, 4'h0, 0));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/atp_printer_arbiter.md
# atp_printer_arbiter

Shares the single receipt printer of a multi-kiosk ATP installation among N per-kiosk ATP machine controllers. Each kiosk raises a print request when its transaction completes. The arbiter grants the printer round-robin, issues a start pulse tagged with the kiosk index, holds the grant until the printer reports done, then returns a per-kiosk completion pulse. It sits between the kiosk controllers' printReceipt stage and the printer interface.

## Interface
- `N_KIOSK`, default 4, number of requesting kiosks (2..16)
- `TIMEOUT_CYCLES`, default 1024, maximum cycles in PRINT before abort (used only with the timeout feature)
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `req`  in  N_KIOSK  level print request, one bit per kiosk
- `grant`  out  N_KIOSK  one-hot printer ownership
- `job_done`  out  N_KIOSK  one-hot 1-cycle pulse, job finished normally
- `job_err`  out  N_KIOSK  one-hot 1-cycle pulse, job aborted by timeout (constant 0 without the timeout feature)
- `prn_start`  out  1  1-cycle pulse, start printing
- `prn_kiosk_id`  out  $clog2(N_KIOSK)  index of the granted kiosk; valid while any grant bit is set
- `prn_done`  in  1  1-cycle pulse from printer, job complete
- `prn_abort`  out  1  1-cycle pulse, cancel current print (timeout feature only)
- `busy`  out  1  high in every state except IDLE

## Operation
- Reset values: all outputs 0; state IDLE; round-robin pointer `last` = N_KIOSK-1, so kiosk 0 has first priority.
- FSM states:
  - **IDLE**: if `req != 0`, pick the first set bit searching from `last+1` with wrap-around. Latch the index and go to START. Otherwise stay.
  - **START**: `grant[idx]`=1, `prn_start`=1, `prn_kiosk_id`=idx. Go unconditionally to PRINT. `prn_done` is ignored here.
  - **PRINT**: `grant[idx]` held. On `prn_done`, go to RELEASE with status OK. On timeout, go to RELEASE with status ERR.
  - **RELEASE**: `grant`=0. Pulse `job_done[idx]` (OK) or `job_err[idx]` (ERR). Set `last`=idx. Go to IDLE.
- After a grant, `req` is not sampled until IDLE. A kiosk dropping `req` mid-job does not cancel the job.
- A kiosk must deassert `req` on seeing `job_done` or `job_err`. A `req` still high in IDLE counts as a new request at the lowest round-robin priority.
- Simultaneous requests: exactly one is granted per job. A continuously requesting kiosk is served at most once per N_KIOSK jobs while others request.
- Single requester repeatedly requesting is served back-to-back.

## Timing
- Request to grant: `req` high in IDLE at edge n → `grant` and `prn_start` high in cycle n+1.
- Minimum job: IDLE → START → PRINT → RELEASE → IDLE. `prn_done` in the first PRINT cycle gives `job_done` 2 cycles after `prn_start`.
- Back-to-back jobs: 4 cycles from one `prn_start` to the next when `prn_done` arrives at the earliest point.
- Reset mid-job: immediate return to IDLE with all outputs 0 and the pointer reinitialised. No completion pulses.

## Configuration
- **`ATP_PRN_TIMEOUT_EN` defined**:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) is cleared on entry to PRINT and increments each PRINT cycle.
  - When it reaches TIMEOUT_CYCLES without `prn_done`: pulse `prn_abort` for one cycle, go to RELEASE with ERR.
  - If `prn_done` and the timeout occur in the same cycle, `prn_done` wins: no abort, status OK.
- **`ATP_PRN_TIMEOUT_EN` undefined**: PRINT waits for `prn_done` indefinitely. `prn_abort` and `job_err` are tied to 0 and no counter is instantiated.

## Structure
- Shared package `atp_pkg` holds:
  - the FSM state enum `arb_state_t` (IDLE, START, PRINT, RELEASE);
  - the job status type (OK/ERR);
  - the default kiosk count and timeout constants.
- Sub-module `atp_rr_pick`: purely combinational round-robin picker. Inputs are `req` and `last`; outputs are `valid` and `idx`. It is reusable by other shared-resource arbiters in the design.

## Test plan
- Reset, then `req`=0001 → `grant`=0001 and `prn_start` in the next cycle, `prn_kiosk_id`=0. `prn_done` 5 cycles later → `job_done`=0001 one cycle after `prn_done`, `busy` low one cycle after that.
- `req`=1111 held, with `prn_done` 3 cycles after each start → grant order 0,1,2,3,0. No kiosk is served twice before all four are served.
- `req`=0100 dropped during PRINT → job continues, `job_done`=0100 on `prn_done`.
- Reset asserted in PRINT → next sampled cycle shows `grant`=0 and `busy`=0. After release, `req`=1010 → kiosk 1 granted first.
- With `ATP_PRN_TIMEOUT_EN`, TIMEOUT_CYCLES=8, no `prn_done` → `prn_abort` and `job_err`=0001 after 8 PRINT cycles. In the same setup, `prn_done` on cycle 8 → `job_done`, no abort.
- Without `ATP_PRN_TIMEOUT_EN`, no `prn_done` for 5000 cycles → grant held throughout, `prn_abort`/`job_err` never asserted.
